// File: rtl/gpio_irq_ctrl_pkg.sv
// Purpose: shared register map and helpers for the GPIO controller family.
// Holds the register byte offsets, the decoded address width and the read
// value returned for unimplemented offsets.
package gpio_irq_ctrl_pkg;

    localparam int unsigned ADDRWIDTH = 8;
    localparam int unsigned DATAWIDTH = 32;

    localparam logic [ADDRWIDTH-1:0] REG_ADDR_IN_SYNC     = 8'h00;
    localparam logic [ADDRWIDTH-1:0] REG_ADDR_INT_EN      = 8'h04;
    localparam logic [ADDRWIDTH-1:0] REG_ADDR_INT_TYPE    = 8'h08;
    localparam logic [ADDRWIDTH-1:0] REG_ADDR_INT_POL     = 8'h0C;
    localparam logic [ADDRWIDTH-1:0] REG_ADDR_INT_STATUS  = 8'h10;
    localparam logic [ADDRWIDTH-1:0] REG_ADDR_INT_PENDING = 8'h14;

    localparam logic [DATAWIDTH-1:0] DEFAULT_REG_VALUE = 32'hFAB_DEF_AC;

    // Expand four Wishbone byte strobes into a 32-bit bit mask.
    function automatic logic [DATAWIDTH-1:0] byte_mask(input logic [3:0] stb);
        return {{8{stb[3]}}, {8{stb[2]}}, {8{stb[1]}}, {8{stb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_irq_ctrl_sync.sv
// Purpose: per-bit two-flop synchroniser plus a history flop for edge detect.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   d_i        raw asynchronous pin values
//   sync_o     synchronised pin values (second synchroniser flop)
//   rise_c_o   combinational rising-edge strobe per bit
//   fall_c_o   combinational falling-edge strobe per bit
module gpio_sync_edge #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_c_o,
    output logic [WIDTH-1:0] fall_c_o
);

    logic [WIDTH-1:0] sync0_q;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] prev_q;

    // prev resets with sync1 so the first post-reset sample is never an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync0_q <= '0;
            sync1_q <= '0;
            prev_q  <= '0;
        end else begin
            sync0_q <= d_i;
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
        end
    end

    assign sync_o   = sync1_q;
    assign rise_c_o = sync1_q & ~prev_q;
    assign fall_c_o = ~sync1_q & prev_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Purpose: Wishbone-slave interrupt controller for GPIO input pins.
// Synchronises the pins, detects per-bit edge/level events, latches them into
// a sticky W1C status register and drives one combined interrupt line.
// Ports:
//   WBs_CLK_i       Wishbone clock (only clock)
//   WBs_RST_n_i     asynchronous active-low reset
//   WBs_ADR_i       byte address; [16:8] module decode, [7:2] register select
//   WBs_CYC_i       bus cycle
//   WBs_BYTE_STB_i  byte enables
//   WBs_WE_i        write enable
//   WBs_STB_i       strobe
//   WBs_DAT_i       write data
//   WBs_DAT_o       read data (combinational mux)
//   WBs_ACK_o       registered acknowledge, one wait state per access
//   GPIO_in_i       raw pin values, asynchronous
//   IRQ_o           registered combined interrupt, active high
module gpio_irq_ctrl #(
    parameter logic [16:0] MODULE_OFFSET     = 17'h0_2000,
    parameter logic [31:0] DEFAULT_REG_VALUE = gpio_irq_ctrl_pkg::DEFAULT_REG_VALUE,
    parameter int unsigned GPIO_WIDTH        = 32
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_n_i,
    input  logic [16:0]           WBs_ADR_i,
    input  logic                  WBs_CYC_i,
    input  logic [3:0]            WBs_BYTE_STB_i,
    input  logic                  WBs_WE_i,
    input  logic                  WBs_STB_i,
    input  logic [31:0]           WBs_DAT_i,
    output logic [31:0]           WBs_DAT_o,
    output logic                  WBs_ACK_o,
    input  logic [GPIO_WIDTH-1:0] GPIO_in_i,
    output logic                  IRQ_o
);

    import gpio_irq_ctrl_pkg::*;

    localparam int unsigned SELW = ADDRWIDTH - 2;
    // Bits at or above GPIO_WIDTH are forced to zero everywhere.
    localparam logic [31:0] GPIO_MASK = 32'((64'd1 << GPIO_WIDTH) - 64'd1);

    logic [31:0] int_en_q,   int_en_d;
    logic [31:0] int_type_q, int_type_d;
    logic [31:0] int_pol_q,  int_pol_d;
    logic [31:0] status_q,   status_d;
    logic        ack_q,      ack_d;
    logic        irq_q,      irq_d;

    logic [GPIO_WIDTH-1:0] sync1;
    logic [GPIO_WIDTH-1:0] rise_c;
    logic [GPIO_WIDTH-1:0] fall_c;

    logic [31:0]     sync1_w;
    logic [31:0]     rise_w;
    logic [31:0]     fall_w;
    logic [31:0]     event_c;
    logic [31:0]     wmask_c;
    logic [31:0]     w1c_c;
    logic            decode_c;
    logic            access_c;
    logic            wr_c;
    logic [SELW-1:0] reg_sel;
    logic            unused_adr;

    gpio_sync_edge #(
        .WIDTH (GPIO_WIDTH)
    ) u_sync (
        .clk_i    (WBs_CLK_i),
        .rst_ni   (WBs_RST_n_i),
        .d_i      (GPIO_in_i),
        .sync_o   (sync1),
        .rise_c_o (rise_c),
        .fall_c_o (fall_c)
    );

    assign sync1_w = 32'(sync1);
    assign rise_w  = 32'(rise_c);
    assign fall_w  = 32'(fall_c);

    // Bus decode; the ~ack term gives one wait state and a single commit per write.
    assign decode_c   = (WBs_ADR_i[16:8] == MODULE_OFFSET[16:8]);
    assign access_c   = decode_c & WBs_CYC_i & WBs_STB_i & ~ack_q;
    assign wr_c       = access_c & WBs_WE_i;
    assign reg_sel    = WBs_ADR_i[ADDRWIDTH-1:2];
    assign wmask_c    = byte_mask(WBs_BYTE_STB_i) & GPIO_MASK;
    assign unused_adr = ^WBs_ADR_i[1:0];

    // Per-bit event: rising/falling edge in edge mode, pin == POL in level mode.
    assign event_c = ((~int_type_q & ~int_pol_q & rise_w)
                    | (~int_type_q &  int_pol_q & fall_w)
                    | ( int_type_q & ~(sync1_w ^ int_pol_q))) & GPIO_MASK;

    // Register writes, W1C and status/IRQ next state.
    always_comb begin
        int_en_d   = int_en_q;
        int_type_d = int_type_q;
        int_pol_d  = int_pol_q;
        w1c_c      = '0;
        if (wr_c) begin
            unique case (reg_sel)
                REG_ADDR_INT_EN[ADDRWIDTH-1:2]:
                    int_en_d = (int_en_q & ~wmask_c) | (WBs_DAT_i & wmask_c);
                REG_ADDR_INT_TYPE[ADDRWIDTH-1:2]:
                    int_type_d = (int_type_q & ~wmask_c) | (WBs_DAT_i & wmask_c);
                REG_ADDR_INT_POL[ADDRWIDTH-1:2]:
                    int_pol_d = (int_pol_q & ~wmask_c) | (WBs_DAT_i & wmask_c);
                REG_ADDR_INT_STATUS[ADDRWIDTH-1:2]:
                    w1c_c = WBs_DAT_i & wmask_c;
                default: ;
            endcase
        end
        // Set has priority over a coincident clear.
        status_d = ((status_q & ~w1c_c) | event_c) & GPIO_MASK;
        ack_d    = access_c;
        irq_d    = |(status_q & int_en_q);
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            int_en_q   <= '0;
            int_type_q <= '0;
            int_pol_q  <= '0;
            status_q   <= '0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            int_en_q   <= int_en_d;
            int_type_q <= int_type_d;
            int_pol_q  <= int_pol_d;
            status_q   <= status_d;
            ack_q      <= ack_d;
            irq_q      <= irq_d;
        end
    end

    // Read mux on the register select alone.
    always_comb begin
        WBs_DAT_o = DEFAULT_REG_VALUE;
        unique case (reg_sel)
            REG_ADDR_IN_SYNC[ADDRWIDTH-1:2]:     WBs_DAT_o = sync1_w;
            REG_ADDR_INT_EN[ADDRWIDTH-1:2]:      WBs_DAT_o = int_en_q;
            REG_ADDR_INT_TYPE[ADDRWIDTH-1:2]:    WBs_DAT_o = int_type_q;
            REG_ADDR_INT_POL[ADDRWIDTH-1:2]:     WBs_DAT_o = int_pol_q;
            REG_ADDR_INT_STATUS[ADDRWIDTH-1:2]:  WBs_DAT_o = status_q;
            REG_ADDR_INT_PENDING[ADDRWIDTH-1:2]: WBs_DAT_o = status_q & int_en_q;
            default: ;
        endcase
    end

    assign WBs_ACK_o = ack_q;
    assign IRQ_o     = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed testbench for gpio_irq_ctrl. All tasks start and end just after a
// falling clock edge; outputs are sampled there, away from the rising edge.
module tb_gpio_irq_ctrl;

    localparam logic [16:0] BASE = 17'h0_2000;
    localparam logic [7:0]  R_IN = 8'h00, R_EN = 8'h04, R_TYPE = 8'h08,
                            R_POL = 8'h0C, R_STAT = 8'h10, R_PEND = 8'h14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [16:0] adr;
    logic        cyc, we, stb;
    logic [3:0]  bstb;
    logic [31:0] dat_w, dat_r;
    logic        ack, irq;
    logic [31:0] gpio;

    int n_vec = 0;
    int n_err = 0;

    gpio_irq_ctrl #(
        .MODULE_OFFSET     (17'h0_2000),
        .DEFAULT_REG_VALUE (32'hFAB_DEF_AC),
        .GPIO_WIDTH        (32)
    ) dut (
        .WBs_CLK_i      (clk),
        .WBs_RST_n_i    (rst_n),
        .WBs_ADR_i      (adr),
        .WBs_CYC_i      (cyc),
        .WBs_BYTE_STB_i (bstb),
        .WBs_WE_i       (we),
        .WBs_STB_i      (stb),
        .WBs_DAT_i      (dat_w),
        .WBs_DAT_o      (dat_r),
        .WBs_ACK_o      (ack),
        .GPIO_in_i      (gpio),
        .IRQ_o          (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // One access: ACK must be high after exactly one edge and low after the next.
    task automatic wb_access(input logic [16:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd);
        adr = a; we = w; dat_w = d; bstb = s; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd = dat_r;
        n_vec++;
        if (ack !== 1'b1) begin
            n_err++;
            $display("FAIL ack_wait1 adr=%h: got %b expected 1", a, ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (ack !== 1'b0) begin
            n_err++;
            $display("FAIL ack_low adr=%h: got %b expected 0", a, ack);
        end
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_access(BASE | 17'(off), 1'b1, d, s, dummy);
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] rd);
        wb_access(BASE | 17'(off), 1'b0, 32'h0, 4'hF, rd);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        int acks;
        // Reset arrives mid-write: no ACK and the write must not land.
        adr = BASE | 17'(R_EN); we = 1'b1; dat_w = 32'hFF; bstb = 4'hF; cyc = 1'b1; stb = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (ack !== 1'b0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got ack=%b irq=%b expected 0 0", ack, irq);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst_n = 1'b1;
        tick(1);
        wb_read(R_EN, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_en: got %h expected 0", rd); end
        wb_read(R_TYPE, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_type: got %h expected 0", rd); end
        wb_read(R_POL, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_pol: got %h expected 0", rd); end
        wb_read(R_STAT, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h expected 0", rd); end
        wb_read(8'h18, rd);
        n_vec++; if (rd !== 32'hFABDEFAC) begin n_err++; $display("FAIL default_value: got %h expected fabdefac", rd); end
        // Another module's address window must never be acknowledged.
        adr = 17'h0_3004; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        acks = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        n_vec++; if (acks !== 0) begin n_err++; $display("FAIL foreign_decode: got %0d acks expected 0", acks); end
    endtask

    task automatic test_rising_edge;
        logic [31:0] rd;
        wb_write(R_EN, 32'h1, 4'hF);
        wb_write(R_TYPE, 32'h0, 4'hF);
        wb_write(R_POL, 32'h0, 4'hF);
        gpio[0] = 1'b1;
        tick(3);  // E0, E1, E2: status set, IRQ not yet
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rise_irq_e2: got %b expected 0", irq); end
        tick(1);  // E3
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL rise_irq_e3: got %b expected 1", irq); end
        wb_read(R_STAT, rd);
        n_vec++; if (rd !== 32'h1) begin n_err++; $display("FAIL rise_status: got %h expected 1", rd); end
        wb_write(R_STAT, 32'h1, 4'hF);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rise_w1c_irq: got %b expected 0", irq); end
        wb_read(R_STAT, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rise_w1c_status: got %h expected 0", rd); end
    endtask

    task automatic test_falling_masked;
        logic [31:0] rd;
        wb_write(R_EN, 32'h0, 4'hF);
        wb_write(R_POL, 32'h20, 4'hF);
        gpio[5] = 1'b1;
        tick(4);
        gpio[5] = 1'b0;
        tick(4);
        wb_read(R_STAT, rd);
        n_vec++; if (rd !== 32'h20) begin n_err++; $display("FAIL fall_status: got %h expected 20", rd); end
        wb_read(R_PEND, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL fall_pending: got %h expected 0", rd); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL fall_irq_masked: got %b expected 0", irq); end
        wb_write(R_EN, 32'h20, 4'hF);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL fall_irq_enabled: got %b expected 1", irq); end
        wb_read(R_PEND, rd);
        n_vec++; if (rd !== 32'h20) begin n_err++; $display("FAIL fall_pending_en: got %h expected 20", rd); end
        wb_write(R_STAT, 32'h20, 4'hF);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL fall_w1c_irq: got %b expected 0", irq); end
        wb_write(R_EN, 32'h0, 4'hF);
    endtask

    task automatic test_level;
        logic [31:0] rd;
        wb_write(R_POL, 32'h08, 4'hF);
        wb_write(R_TYPE, 32'h08, 4'hF);
        gpio[3] = 1'b1;
        tick(4);
        wb_read(R_STAT, rd);
        n_vec++; if (rd !== 32'h08) begin n_err++; $display("FAIL level_status: got %h expected 8", rd); end
        wb_write(R_EN, 32'h08, 4'hF);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL level_irq: got %b expected 1", irq); end
        wb_write(R_STAT, 32'h08, 4'hF);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL level_irq_hold: got %b expected 1", irq); end
        wb_read(R_STAT, rd);
        n_vec++; if (rd !== 32'h08) begin n_err++; $display("FAIL level_reassert: got %h expected 8", rd); end
        gpio[3] = 1'b0;
        tick(4);
        wb_read(R_STAT, rd);
        n_vec++; if (rd !== 32'h08) begin n_err++; $display("FAIL level_sticky: got %h expected 8", rd); end
        wb_write(R_STAT, 32'h08, 4'hF);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL level_clear_irq: got %b expected 0", irq); end
        wb_write(R_EN, 32'h0, 4'hF);
        wb_write(R_TYPE, 32'h0, 4'hF);
        wb_write(R_POL, 32'h0, 4'hF);
    endtask

    task automatic test_collision;
        logic [31:0] rd;
        gpio[2] = 1'b1;
        tick(2);  // E0, E1; the W1C commits on E2 together with the edge
        wb_write(R_STAT, 32'h4, 4'hF);
        wb_read(R_STAT, rd);
        n_vec++; if (rd !== 32'h4) begin n_err++; $display("FAIL collision_set_wins: got %h expected 4", rd); end
        wb_write(R_STAT, 32'h4, 4'hF);
        wb_read(R_STAT, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL collision_clear: got %h expected 0", rd); end
    endtask

    task automatic test_byte_strobes;
        logic [31:0] rd;
        wb_write(R_EN, 32'hFFFF_FFFF, 4'b0010);
        wb_read(R_EN, rd);
        n_vec++; if (rd !== 32'h0000_FF00) begin n_err++; $display("FAIL bstb_en: got %h expected 0000ff00", rd); end
        gpio = 32'h0;
        tick(4);
        gpio = 32'h0101_0101;
        tick(4);
        wb_read(R_STAT, rd);
        n_vec++; if (rd !== 32'h0101_0101) begin n_err++; $display("FAIL bstb_status: got %h expected 01010101", rd); end
        wb_read(R_IN, rd);
        n_vec++; if (rd !== 32'h0101_0101) begin n_err++; $display("FAIL in_sync: got %h expected 01010101", rd); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL bstb_irq: got %b expected 1", irq); end
        wb_read(R_PEND, rd);
        n_vec++; if (rd !== 32'h0000_0100) begin n_err++; $display("FAIL bstb_pending: got %h expected 00000100", rd); end
        wb_write(R_STAT, 32'hFFFF_FFFF, 4'b0001);
        wb_read(R_STAT, rd);
        n_vec++; if (rd !== 32'h0101_0100) begin n_err++; $display("FAIL bstb_w1c: got %h expected 01010100", rd); end
        // Read-only and unmapped writes are acknowledged but change nothing.
        wb_write(R_IN, 32'hFFFF_FFFF, 4'hF);
        wb_write(8'h18, 32'h1234_5678, 4'hF);
        wb_read(R_IN, rd);
        n_vec++; if (rd !== 32'h0101_0101) begin n_err++; $display("FAIL ro_write: got %h expected 01010101", rd); end
        wb_read(8'h18, rd);
        n_vec++; if (rd !== 32'hFABDEFAC) begin n_err++; $display("FAIL unmapped_write: got %h expected fabdefac", rd); end
    endtask

    initial begin
        rst_n = 1'b0;
        adr = '0; cyc = 1'b0; we = 1'b0; stb = 1'b0; bstb = '0; dat_w = '0;
        gpio = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        test_reset();
        test_rising_edge();
        test_falling_masked();
        test_level();
        test_collision();
        test_byte_strobes();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
